md_sequencer: RTL and testbench
===============================

Name: md_sequencer

Overview:
- Multi-cycle multiply/divide controller for the Mini-SRC ALU path.
- Accepts one signed MUL or DIV request through a start/busy/done handshake.
- Runs a WIDTH-iteration shift-add (MUL) or restoring-subtract (DIV) sequence on operand magnitudes, then applies signs.
- Writes the result into the HI/LO outputs that feed the HI and LO registers.

Parameters:
- WIDTH, 32, operand width; the iteration count equals WIDTH.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- clear  input  1  reset; synchronous, active-high.
- start  input  1  request strobe; sampled only in IDLE.
- op_div  input  1  1 = signed divide, 0 = signed multiply.
- operand_a  input  WIDTH  dividend or multiplicand (two's complement).
- operand_b  input  WIDTH  divisor or multiplier (two's complement).
- hi  output  WIDTH  DIV: remainder; MUL: product[2W-1:W].
- lo  output  WIDTH  DIV: quotient; MUL: product[W-1:0].
- busy  output  1  high in ITER and FIXUP.
- done  output  1  one-cycle pulse while in DONE; hi/lo are valid then.
- div_by_zero  output  1  set on a DIV whose divisor is 0; held until the next accepted start.

Behaviour:
- Clock and reset: one clock (clock); reset (clear) is synchronous, active-high.
- Reset: state=IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0, iteration counter=0.
- clear asserted mid-operation aborts it. Outputs return to reset values at that edge and no done is produced.
- States: IDLE, ITER, FIXUP, DONE.
- IDLE: when start=1, latch at the edge:
  - op_div;
  - sign flags: MUL sign = a[W-1]^b[W-1]; DIV quotient sign = same; DIV remainder sign = a[W-1];
  - operand magnitudes; counter=WIDTH-1;
  - clear div_by_zero.
- IDLE exit:
  - DIV with b==0: set div_by_zero, go to FIXUP.
  - Otherwise go to ITER.
  - start=0: stay in IDLE.
- ITER, DIV: 2W-bit partial remainder shifts left one bit and takes the next dividend magnitude bit (MSB first). If rem[W-1:0] >= |b|, subtract |b| and set quotient bit.
- ITER, MUL: if the multiplier magnitude's current bit (LSB first) is 1, add the multiplicand magnitude to the upper half of the 2W-bit accumulator. Then shift the accumulator right by 1 with carry-in.
- ITER counting: counter decrements each cycle; leave to FIXUP after the iteration with counter==0. ITER lasts exactly WIDTH cycles.
- FIXUP writes hi/lo:
  - MUL: negate the 2W-bit product if its sign is 1.
  - DIV: negate quotient and remainder by their respective signs; truncation toward zero, remainder takes the dividend's sign.
  - Divide-by-zero: lo=0, hi=operand_a unchanged.
  - Then go to DONE.
- DONE: done=1 for one cycle, busy=0, then go to IDLE. start during DONE is ignored.
- Latency: done is high in the cycle after edge E+WIDTH+1, where E is the accepting edge (33 edges at WIDTH=32). Divide-by-zero: after edge E+1.
- Output holding: hi/lo change only in FIXUP or on clear, and otherwise hold through IDLE. Operand inputs may change freely after the accepting edge.
- Overflow: most-negative / -1 wraps to lo=0x80000000, hi=0, with no flag. MUL of two most-negative operands gives hi=0x40000000, lo=0.
- start held high continuously: a new operation is accepted each time the block returns to IDLE.

Optional Feature:
- Macro: MD_EARLY_OUT_EN.
- Defined, the IDLE exit goes straight to FIXUP (latency = divide-by-zero latency) in two cases:
  - DIV with |a| < |b| (and b!=0): lo=0, hi=operand_a.
  - MUL with a==0 or b==0: hi=lo=0.
- Undefined, every non-divide-by-zero operation takes the full WIDTH iterations and gives identical results.

Test Plan:
- DIV 100 / 7 -> lo=14, hi=2, div_by_zero=0, done after edge E+33, busy high for 33 cycles.
- DIV -100 / 7 -> lo=0xFFFFFFF2, hi=0xFFFFFFFE. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV 100 / 0 -> lo=0, hi=100, div_by_zero=1, done after edge E+1. Next DIV 9/3 clears the flag -> lo=3, hi=0.
- MUL -3 * 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. MUL 0x7FFFFFFF * 0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001.
- clear at the 10th ITER cycle -> busy=0, done never pulses, hi=lo=0. Next MUL 6*7 -> lo=42, hi=0.
- With MD_EARLY_OUT_EN: DIV 5 / 9 -> lo=0, hi=5, done after edge E+1. Without the macro: same result, done after edge E+33.

Source files
------------

// File: rtl/md_sequencer.sv
// Multi-cycle signed multiply/divide sequencer driving the HI/LO result registers.
// Optional MD_EARLY_OUT_EN skips the iteration phase when the result is trivially known.
module md_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    clear,
    input  logic                    start,
    input  logic                    op_div,
    input  logic signed [WIDTH-1:0] operand_a,
    input  logic signed [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0]        hi,
    output logic [WIDTH-1:0]        lo,
    output logic                    busy,
    output logic                    done,
    output logic                    div_by_zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIXUP, S_DONE} state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_div;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic [WIDTH-1:0]     r_mcand;
    logic [2*WIDTH-1:0]   r_acc;

    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic                 w_early;
    logic [2*WIDTH-1:0]   w_sh;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_acc_nxt;

    function automatic logic [WIDTH-1:0] f_abs(input logic signed [WIDTH-1:0] v);
        logic [WIDTH-1:0] m;
        m = v[WIDTH-1] ? -v : v;
        return m;
    endfunction

    function automatic logic [WIDTH-1:0] f_cneg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] f_cneg2(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign w_abs_a = f_abs(operand_a);
    assign w_abs_b = f_abs(operand_b);

`ifdef MD_EARLY_OUT_EN
    assign w_early = op_div ? (w_abs_a < w_abs_b)
                            : ((operand_a == '0) || (operand_b == '0));
`else
    assign w_early = 1'b0;
`endif

    // DIV keeps {remainder, dividend/quotient}; MUL keeps {partial product, multiplier}
    always_comb begin
        w_sh      = r_acc << 1;
        w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
        w_acc_nxt = r_acc;
        if (r_div) begin
            if (w_sh[2*WIDTH-1:WIDTH] >= r_mcand)
                w_acc_nxt = {w_sh[2*WIDTH-1:WIDTH] - r_mcand, w_sh[WIDTH-1:1], 1'b1};
            else
                w_acc_nxt = w_sh;
        end else begin
            if (r_acc[0])
                w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
            else
                w_acc_nxt = {1'b0, r_acc[2*WIDTH-1:1]};
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            hi          <= '0;
            lo          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_div       <= op_div;
                        r_neg_q     <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                        r_neg_r     <= operand_a[WIDTH-1];
                        r_mcand     <= op_div ? w_abs_b : w_abs_a;
                        r_cnt       <= CNT_W'(WIDTH - 1);
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        // {|a|, 0} makes FIXUP yield quotient 0 and remainder == a
                        if (op_div && (operand_b == '0)) begin
                            div_by_zero <= 1'b1;
                            r_acc       <= {w_abs_a, {WIDTH{1'b0}}};
                            r_state     <= S_FIXUP;
                        end else if (w_early) begin
                            r_acc   <= op_div ? {w_abs_a, {WIDTH{1'b0}}} : '0;
                            r_state <= S_FIXUP;
                        end else begin
                            r_acc   <= op_div ? {{WIDTH{1'b0}}, w_abs_a} : {{WIDTH{1'b0}}, w_abs_b};
                            r_state <= S_ITER;
                        end
                    end
                end
                S_ITER: begin
                    r_acc <= w_acc_nxt;
                    if (r_cnt == '0)
                        r_state <= S_FIXUP;
                    else
                        r_cnt <= r_cnt - CNT_W'(1);
                end
                S_FIXUP: begin
                    if (r_div) begin
                        lo <= f_cneg(r_acc[WIDTH-1:0], r_neg_q);
                        hi <= f_cneg(r_acc[2*WIDTH-1:WIDTH], r_neg_r);
                    end else begin
                        {hi, lo} <= f_cneg2(r_acc, r_neg_q);
                    end
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed and randomized bench for md_sequencer against a 64-bit arithmetic reference model.
module tb_md_sequencer;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         clear;
    logic         start;
    logic         op_div;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int n_chk  = 0;
    int n_fail = 0;
    logic [W-1:0] last_hi, last_lo;

    md_sequencer #(.WIDTH(W)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .op_div      (op_div),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic d, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] eh, output logic [W-1:0] el,
                                  output logic edbz, output int elat);
        longint la, lb, q, r;
        logic [63:0] p;
        la   = longint'($signed(a));
        lb   = longint'($signed(b));
        edbz = 1'b0;
        elat = W + 1;
        if (d) begin
            if (b == '0) begin
                eh = a; el = '0; edbz = 1'b1; elat = 1;
            end else begin
                q  = la / lb;
                r  = la % lb;
                el = q[W-1:0];
                eh = r[W-1:0];
`ifdef MD_EARLY_OUT_EN
                if (((la < 0) ? -la : la) < ((lb < 0) ? -lb : lb)) elat = 1;
`endif
            end
        end else begin
            p = la * lb;
            eh = p[63:32];
            el = p[31:0];
`ifdef MD_EARLY_OUT_EN
            if (a == '0 || b == '0) elat = 1;
`endif
        end
    endfunction

    task automatic run_op(input string tag, input logic d, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] eh, el;
        logic edbz;
        int elat, k, nbusy;
        model(d, a, b, eh, el, edbz, elat);
        @(negedge clock);
        op_div = d; operand_a = a; operand_b = b; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        operand_a = $urandom; operand_b = $urandom; op_div = 1'($urandom_range(0, 1));
        nbusy = 0;
        for (k = 0; k < 100; k++) begin
            if (k > 0) begin @(posedge clock); #1; end
            if (done) break;
            if (busy) nbusy++;
        end
        chk({tag, ".latency"}, 64'(k), 64'(elat));
        chk({tag, ".busy_cycles"}, 64'(nbusy), 64'(elat));
        chk({tag, ".hi"}, 64'(hi), 64'(eh));
        chk({tag, ".lo"}, 64'(lo), 64'(el));
        chk({tag, ".dbz"}, 64'(div_by_zero), 64'(edbz));
        chk({tag, ".busy_at_done"}, 64'(busy), 64'(0));
        @(posedge clock); #1;
        chk({tag, ".done_pulse"}, 64'(done), 64'(0));
        last_hi = eh;
        last_lo = el;
    endtask

    initial begin
        int seen;
        logic d;
        logic [W-1:0] a, b;
        clear = 1'b1; start = 1'b0; op_div = 1'b0; operand_a = '0; operand_b = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset.hi", 64'(hi), 64'(0));
        chk("reset.lo", 64'(lo), 64'(0));
        chk("reset.busy", 64'(busy), 64'(0));
        chk("reset.done", 64'(done), 64'(0));
        chk("reset.dbz", 64'(div_by_zero), 64'(0));
        clear = 1'b0;

        run_op("div_100_7", 1'b1, 32'd100, 32'd7);
        run_op("div_m100_7", 1'b1, -32'sd100, 32'd7);
        run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_by_zero", 1'b1, 32'd100, 32'd0);
        run_op("div_9_3", 1'b1, 32'd9, 32'd3);
        run_op("mul_m3_5", 1'b0, -32'sd3, 32'd5);
        run_op("mul_max", 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        run_op("mul_minneg", 1'b0, 32'h8000_0000, 32'h8000_0000);
        run_op("div_5_9", 1'b1, 32'd5, 32'd9);
        run_op("div_m7_m2", 1'b1, -32'sd7, -32'sd2);

        repeat (3) @(posedge clock);
        #1;
        chk("hold.hi", 64'(hi), 64'(last_hi));
        chk("hold.lo", 64'(lo), 64'(last_lo));

        // abort in the 10th ITER cycle
        @(negedge clock);
        op_div = 1'b0; operand_a = 32'd123; operand_b = 32'd456; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        @(negedge clock);
        clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0;
        chk("abort.busy", 64'(busy), 64'(0));
        chk("abort.done", 64'(done), 64'(0));
        chk("abort.hi", 64'(hi), 64'(0));
        chk("abort.lo", 64'(lo), 64'(0));
        seen = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done) seen++;
        end
        chk("abort.no_done", 64'(seen), 64'(0));
        run_op("mul_6_7", 1'b0, 32'd6, 32'd7);

        for (int i = 0; i < 20; i++) begin
            d = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
            case ($urandom_range(0, 4))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 30));
                2:       b = -W'($urandom_range(1, 30));
                default: b = W'($urandom);
            endcase
            run_op($sformatf("rand%0d", i), d, a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
